// File: rtl/sync_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_timing_gen                                            |
// | Description : Pulse-repetition timing generator. Emits a one-cycle sync  |
// |               strobe at the start of every PRI and a TX gate lasting     |
// |               numdig x tb cycles. Runs continuously or for a fixed       |
// |               burst of PRIs, then strobes done.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports:                                                                   |
// |   i_clk        in   1      system clock                                  |
// |   i_rst        in   1      synchronous reset, active high                |
// |   i_enable     in   1      run request (level)                           |
// |   i_periodo    in   CNT_W  PRI length in clocks (min 2)                  |
// |   i_numdig     in   CNT_W  code digits per pulse                         |
// |   i_tb         in   CNT_W  clocks per code digit                         |
// |   i_npulsos    in   CNT_W  PRIs per burst, 0 = continuous                |
// |   i_trig       in   1      external trigger (EXT_TRIG_EN only, async)    |
// |   o_sinc       out  1      strobe at PRI start                           |
// |   o_gate       out  1      TX gate                                       |
// |   o_busy       out  1      high while generating PRIs                    |
// |   o_pulse_cnt  out  CNT_W  PRIs started since last start from idle       |
// |   o_done       out  1      strobe at end of a finite burst               |
// | Build option: define EXT_TRIG_EN to gate every PRI start on an edge of   |
// |               i_trig.                                                    |
// +--------------------------------------------------------------------------+
module sync_timing_gen #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_periodo,
  input  logic [CNT_W-1:0] i_numdig,
  input  logic [CNT_W-1:0] i_tb,
  input  logic [CNT_W-1:0] i_npulsos,
`ifdef EXT_TRIG_EN
  input  logic             i_trig,
`endif
  output logic             o_sinc,
  output logic             o_gate,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_pulse_cnt,
  output logic             o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;        // position inside the current PRI
  logic [CNT_W-1:0]   per;        // latched P
  logic [CNT_W-1:0]   gate_len;   // latched G, already clamped to P
  logic [CNT_W-1:0]   n_lat;      // latched burst length
  logic [CNT_W-1:0]   pulse_cnt;
  logic               done;

  logic [CNT_W-1:0]   p_in;
  logic [2*CNT_W-1:0] prod;
  logic [CNT_W-1:0]   g_in;
  logic               at_end;
  logic               burst_done;
  logic               trig_ok;
  logic               waiting;
  logic               start_pri;
  logic               first_pri;
  logic               done_nxt;

  // Configuration as it will be latched at the next PRI start.
  assign p_in = (i_periodo < CNT_W'(2)) ? CNT_W'(2) : i_periodo;
  // Full-width product so large numdig x tb clamps to P instead of wrapping.
  assign prod = {{CNT_W{1'b0}}, i_numdig} * {{CNT_W{1'b0}}, i_tb};
  assign g_in = (prod > {{CNT_W{1'b0}}, p_in}) ? p_in : prod[CNT_W-1:0];

  assign at_end     = (cnt == per - 1'b1);
  assign burst_done = (n_lat != '0) && (pulse_cnt == n_lat);

`ifdef EXT_TRIG_EN
  logic sync1, sync2, sync3;
  logic stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      waiting <= 1'b0;
    end else begin
      sync1   <= i_trig;
      sync2   <= sync1;
      sync3   <= sync2;
      waiting <= stall;
    end
  end

  // A rising edge is only consumed when a PRI start is pending; otherwise it
  // simply disappears, which discards mid-PRI triggers.
  assign trig_ok = sync2 & ~sync3;
`else
  assign trig_ok = 1'b1;
  assign waiting = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    start_pri = 1'b0;
    first_pri = 1'b0;
    done_nxt  = 1'b0;
`ifdef EXT_TRIG_EN
    stall     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (i_enable && trig_ok) begin
          state_nxt = RUN;
          start_pri = 1'b1;
          first_pri = 1'b1;
        end
      end
      RUN: begin
        if (at_end) begin
          // Burst completion wins over a simultaneous disable so the done
          // strobe is never lost for a completed burst.
          if (burst_done) begin
            state_nxt = HOLD;
            done_nxt  = 1'b1;
          end else if (!i_enable) begin
            state_nxt = IDLE;
          end else if (trig_ok) begin
            start_pri = 1'b1;
          end else begin
`ifdef EXT_TRIG_EN
            stall     = 1'b1;
`endif
          end
        end
      end
      HOLD: begin
        if (!i_enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      per       <= '0;
      gate_len  <= '0;
      n_lat     <= '0;
      pulse_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= done_nxt;
      if (start_pri) begin
        cnt       <= '0;
        per       <= p_in;
        gate_len  <= g_in;
        n_lat     <= i_npulsos;
        pulse_cnt <= first_pri ? CNT_W'(1) : pulse_cnt + 1'b1;
      end else if (state == RUN && !at_end) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_busy      = (state == RUN);
  assign o_sinc      = o_busy && (cnt == '0);
  assign o_gate      = o_busy && (cnt < gate_len) && !waiting;
  assign o_pulse_cnt = pulse_cnt;
  assign o_done      = done;

endmodule
`default_nettype wire

// File: tb/tb_sync_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sync_timing_gen                                         |
// | Description : Self-checking bench for sync_timing_gen. A PRI-schedule    |
// |               model (start cycle, P, G, burst length) predicts every     |
// |               output each cycle; directed scenarios add literal checks.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sync_timing_gen;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] periodo, numdig, tb, npulsos;
  logic         trig;
  logic         sinc, gate, busy, done;
  logic [W-1:0] pcnt;

  always #5 clk = ~clk;

  sync_timing_gen #(.CNT_W(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
`ifdef EXT_TRIG_EN
    .i_trig      (trig),
`endif
    .i_enable    (enable),
    .i_periodo   (periodo),
    .i_numdig    (numdig),
    .i_tb        (tb),
    .i_npulsos   (npulsos),
    .o_sinc      (sinc),
    .o_gate      (gate),
    .o_busy      (busy),
    .o_pulse_cnt (pcnt),
    .o_done      (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A PRI is described by its start cycle and latched P/G/N; outputs follow
  // from the distance between the visible cycle and that start.
  int        m_state = 0;   // 0 idle, 1 run, 2 hold
  longint    now = 0;       // index of the currently visible cycle
  longint    start = 0;
  longint    mP = 2, mG = 0, mN = 0, mcnt = 0;
  bit        mdone = 1'b0;

  task automatic new_pri(input bit first);
    logic [63:0] prod;
    mP    = (periodo < 2) ? 2 : longint'(periodo);
    prod  = 64'(numdig) * 64'(tb);
    mG    = (prod > 64'(mP)) ? mP : longint'(prod);
    mN    = longint'(npulsos);
    mcnt  = first ? 1 : ((mcnt + 1) & 64'hFFFF_FFFF);
    start = now + 1;
  endtask

  always @(posedge clk) begin
    mdone = 1'b0;
    if (rst) begin
      m_state = 0;
      mcnt    = 0;
    end else begin
      case (m_state)
        0: if (enable) begin m_state = 1; new_pri(1'b1); end
        1: if (now - start == mP - 1) begin
             if (mN != 0 && mcnt == mN) begin m_state = 2; mdone = 1'b1; end
             else if (!enable) m_state = 0;
             else new_pri(1'b0);
           end
        default: if (!enable) m_state = 0;
      endcase
    end
    now++;
  end

  always @(negedge clk) begin
    if (now > 0) begin
      check("m_sinc", sinc, (m_state == 1 && now == start));
      check("m_gate", gate, (m_state == 1 && (now - start) < mG));
      check("m_busy", busy, (m_state == 1));
      check("m_pcnt", pcnt, mcnt);
      check("m_done", done, mdone);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic go_idle();
    int k;
    enable = 1'b0;
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    check("idle_timeout", (k < 100), 1);
    repeat (2) @(negedge clk);
  endtask

  int ns, ng, nd, nb, di, last;

  initial begin
    rst = 1'b1; enable = 1'b1; trig = 1'b0;
    periodo = 20; numdig = 4; tb = 3; npulsos = 0;
    repeat (3) @(negedge clk);
    check("rst_sinc", sinc, 0);
    check("rst_gate", gate, 0);
    check("rst_busy", busy, 0);
    check("rst_pcnt", pcnt, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("start_sinc", sinc, 1);
    check("start_pcnt", pcnt, 1);

    // continuous run
    ns = 0; ng = 0;
    for (int i = 0; i < 100; i++) begin
      ns += sinc; ng += gate;
      if (i == 99) check("cont_pcnt", pcnt, 5);
      @(negedge clk);
    end
    check("cont_sinc_count", ns, 5);
    check("cont_gate_count", ng, 60);
    go_idle();

    // burst of 3
    periodo = 10; numdig = 2; tb = 2; npulsos = 3; enable = 1'b1;
    @(negedge clk);
    ns = 0; nd = 0; nb = 0; di = -1;
    for (int i = 0; i < 45; i++) begin
      ns += sinc;
      if (done) begin nd++; if (di < 0) di = i; end
      if (i >= 31) nb += busy;
      @(negedge clk);
    end
    check("burst_sinc_count", ns, 3);
    check("burst_done_count", nd, 1);
    check("burst_done_index", di, 30);
    check("hold_busy", nb, 0);
    ns = 0;
    for (int i = 0; i < 20; i++) begin ns += sinc; @(negedge clk); end
    check("hold_no_restart", ns, 0);
    enable = 1'b0; @(negedge clk);
    enable = 1'b1; @(negedge clk);
    check("rearm_sinc", sinc, 1);
    check("rearm_pcnt", pcnt, 1);
    go_idle();

    // gate clamped to P
    npulsos = 0; numdig = 8; tb = 5; periodo = 16; enable = 1'b1;
    @(negedge clk);
    ng = 0;
    for (int i = 0; i < 64; i++) begin ng += gate; @(negedge clk); end
    check("clamp_gate_count", ng, 64);
    go_idle();

    // zero gate
    tb = 0; enable = 1'b1;
    @(negedge clk);
    ns = 0; ng = 0;
    for (int i = 0; i < 48; i++) begin ns += sinc; ng += gate; @(negedge clk); end
    check("zero_gate_sinc", ns, 3);
    check("zero_gate_gate", ng, 0);
    go_idle();

    // periodo=1 behaves as 2
    periodo = 1; numdig = 1; tb = 1; enable = 1'b1;
    @(negedge clk);
    ns = 0; ng = 0;
    for (int i = 0; i < 10; i++) begin ns += sinc; ng += gate; @(negedge clk); end
    check("p1_sinc", ns, 5);
    check("p1_gate", ng, 5);
    go_idle();

    // disable mid-PRI: PRI completes, no done
    periodo = 10; numdig = 2; tb = 2; enable = 1'b1;
    @(negedge clk);
    nb = 0; nd = 0;
    for (int i = 0; i < 30; i++) begin
      nb += busy; nd += done;
      if (i == 3) enable = 1'b0;
      @(negedge clk);
    end
    check("drop_busy_cycles", nb, 10);
    check("drop_no_done", nd, 0);

    // period change mid-PRI
    enable = 1'b1;
    @(negedge clk);
    ns = 0; last = -1;
    for (int i = 0; i < 30; i++) begin
      if (sinc) begin ns++; last = i; end
      if (i == 2) periodo = 6;
      @(negedge clk);
    end
    check("chg_sinc_count", ns, 5);
    check("chg_last_sinc", last, 28);
    go_idle();

    // reset mid-gate
    periodo = 20; numdig = 4; tb = 3; enable = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("pre_rst_gate", gate, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_gate", gate, 0);
    check("rst_mid_busy", busy, 0);
    rst = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);

    // randomized operation against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) begin
        periodo = $urandom_range(0, 24);
        numdig  = $urandom_range(0, 6);
        tb      = $urandom_range(0, 5);
        npulsos = $urandom_range(0, 4);
        if ($urandom_range(0, 7) == 0) begin
          numdig = 32'h0001_0000;
          tb     = 32'h0001_0000;
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sync_timing_gen.md
Name: sync_timing_gen

Overview:
Pulse-repetition timing generator for the transmitter chain.
- Produces the one-cycle sync strobe that restarts the phase-code generator at each pulse repetition interval (PRI).
- Produces a TX gate that stays high for the coded-pulse duration (numdig × tb cycles).
- Supports continuous operation or a fixed burst of PRIs, with a done strobe at the end of a burst.
- Sits directly upstream of the code generator/signal stage; o_sinc feeds its sync input.

Parameters:
CNT_W, 32, width of the period counter, the gate counter and all configuration inputs.

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active high
i_enable  input  1  run request; level sensitive
i_periodo  input  CNT_W  PRI length in clock cycles
i_numdig  input  CNT_W  number of code digits per pulse
i_tb  input  CNT_W  clock cycles per code digit
i_npulsos  input  CNT_W  PRIs per burst; 0 = continuous
o_sinc  output  1  one-cycle strobe at the start of each PRI
o_gate  output  1  high while the coded pulse is on air
o_busy  output  1  high in RUN
o_pulse_cnt  output  CNT_W  PRIs started since the last start from IDLE
o_done  output  1  one-cycle strobe at the end of a finite burst

Behaviour:
Reset:
- All outputs are 0. State is IDLE. All counters are cleared.
- Reset has priority over all other inputs.
- Reset asserted mid-run aborts immediately: o_gate drops the next cycle and no o_done is issued.

States:
- IDLE: waiting for a start.
- RUN: generating PRIs.
- HOLD: burst complete; waiting for i_enable to go low.

Transitions:
- IDLE -> RUN: when i_enable is sampled 1.
  - o_sinc=1 and o_gate=1 (if the gate length is nonzero) in the first cycle of RUN. Latency is 1 clock from the enabling edge.
  - o_pulse_cnt=1 in that same cycle.
- RUN:
  - Period counter runs 0..P-1; o_sinc=1 exactly when the counter is 0.
  - At wrap, if i_enable=1 and the burst is not complete, a new PRI starts and o_pulse_cnt increments.
- RUN -> IDLE: i_enable=0 at wrap (P-1). The current PRI always completes; disabling never truncates a gate.
- RUN -> HOLD: i_npulsos≠0 and o_pulse_cnt==i_npulsos at wrap.
  - o_done=1 for one cycle, in the first cycle of HOLD.
- HOLD -> IDLE: when i_enable=0. A new burst therefore requires deassert then reassert of i_enable.

Configuration:
- All inputs are latched at every PRI start (IDLE->RUN and at each wrap).
- Changes mid-PRI take effect at the next PRI.
- P = max(i_periodo, 2).
- Gate length G = i_numdig × i_tb, computed at full 2·CNT_W width, then clamped to P.
  - If G == P, the gate stays high continuously across back-to-back PRIs.
  - If G == 0 (numdig or tb is 0), the gate is never asserted but o_sinc still fires.
- o_gate is high for counter values 0..G-1.

Counters:
- o_pulse_cnt wraps modulo 2^CNT_W in continuous mode.
- o_pulse_cnt is cleared on IDLE->RUN.
- o_busy=0 in IDLE and HOLD.

Optional Feature:
Macro EXT_TRIG_EN.
- Defined: adds input i_trig (1 bit, asynchronous).
  - i_trig passes through a 2-flop synchronizer plus rising-edge detect.
  - Every PRI start (from IDLE or at wrap) additionally requires a detected trigger edge.
  - After the period counter reaches P-1, it holds at P-1 with o_gate=0 until an edge arrives.
  - Start latency from the i_trig rising edge to o_sinc is 3 clocks.
  - Edges that arrive mid-PRI are discarded.
- Undefined: no i_trig port; behaviour is exactly as specified above.

Test Plan:
1. Reset check: i_rst=1 for 3 cycles with i_enable=1 -> all outputs 0. After release: o_sinc at the next edge, o_pulse_cnt=1.
2. Continuous run: periodo=20, numdig=4, tb=3, npulsos=0, enable held -> o_sinc every 20 cycles; o_gate high 12 cycles starting with each o_sinc; o_pulse_cnt=5 after 100 cycles.
3. Burst: periodo=10, numdig=2, tb=2, npulsos=3 -> exactly 3 o_sinc. o_done one cycle after the 30th RUN cycle. o_busy=0 while enable stays high. A second burst starts only after enable toggles low then high.
4. Clamp and degenerate cases:
   - numdig=8, tb=5, periodo=16 -> o_gate continuously high.
   - tb=0 -> o_gate never high, o_sinc still every 16.
   - periodo=1 -> period 2.
5. Mid-run changes:
   - Drop enable at counter 3 of a 10-cycle PRI -> PRI completes, IDLE at cycle 10, no o_done.
   - Change periodo 10->6 mid-PRI -> the next PRI is 6.
   - Assert i_rst mid-gate -> o_gate=0 the next cycle.
6. With EXT_TRIG_EN, periodo=8:
   - i_trig edges spaced 12 cycles apart -> o_sinc 3 clocks after each edge; the counter holds at 7 between PRIs.
   - An edge arriving mid-PRI is ignored.
